// File: rtl/ula_ctrl_pkg.sv
// Shared constants for the ULA sequencer: FSM encodings, default widths, ULA opcodes.
package ula_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned OPW_DEF   = 3;
  localparam int unsigned CNT_W     = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

endpackage

// File: rtl/ula_ctrl_if.sv
// Request, ULA-operand and response signals of the ULA sequencer.
interface ula_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] ula_a;
  logic [WIDTH-1:0] ula_b;
  logic [OPW-1:0]   ula_op;
  logic [WIDTH:0]   ula_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH:0]   rsp_s;
  logic             rsp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  ula_s, rsp_ready,
    output req0_ready, req1_ready,
    output ula_a, ula_b, ula_op,
    output rsp_valid, rsp_s, rsp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output ula_s, rsp_ready,
    input  req0_ready, req1_ready,
    input  ula_a, ula_b, ula_op,
    input  rsp_valid, rsp_s, rsp_id
  );
endinterface

// File: rtl/ula_ctrl_rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester favoured on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req == 2'b11) grant_c = ptr ? 2'b10 : 2'b01;
      else              grant_c = req;
    end
  end

endmodule

// File: rtl/ula_ctrl.sv
// Shares one ULA between two requesters: round-robin accept, fixed-latency wait,
// result returned with requester id over a valid/ready response channel.
module ula_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned OPW     = OPW_DEF,
  parameter int unsigned ULA_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  ula_ctrl_if.slave bus,
  output logic   busy
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ULA_LAT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] ula_a_q, ula_a_d;
  logic [WIDTH-1:0] ula_b_q, ula_b_d;
  logic [OPW-1:0]   ula_op_q, ula_op_d;
  logic [WIDTH:0]   rsp_s_q, rsp_s_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             arb_en;
  logic [1:0]       grant_c;

  // run_q keeps ready low while reset is held and for the first cycle after release
  assign arb_en = run_q && (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .req     ({bus.req1_valid, bus.req0_valid}),
    .ptr     (ptr_q),
    .en      (arb_en),
    .grant_c (grant_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    run_d       = 1'b1;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_op_d    = ula_op_q;
    rsp_s_d     = rsp_s_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_c[1]) begin
          ula_a_d  = bus.req1_a;
          ula_b_d  = bus.req1_b;
          ula_op_d = bus.req1_op;
          rsp_id_d = 1'b1;
          cnt_d    = LAT_INIT;
          state_d  = ST_WAIT;
        end else if (grant_c[0]) begin
          ula_a_d  = bus.req0_a;
          ula_b_d  = bus.req0_b;
          ula_op_d = bus.req0_op;
          rsp_id_d = 1'b0;
          cnt_d    = LAT_INIT;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_s_d     = bus.ula_s;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      run_q       <= 1'b0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_op_q    <= '0;
      rsp_s_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      run_q       <= run_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_op_q    <= ula_op_d;
      rsp_s_q     <= rsp_s_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req0_ready = grant_c[0];
  assign bus.req1_ready = grant_c[1];
  assign bus.ula_a      = ula_a_q;
  assign bus.ula_b      = ula_b_q;
  assign bus.ula_op     = ula_op_q;
  assign bus.rsp_s      = rsp_s_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ula_ctrl.sv
// Scoreboard bench for ula_ctrl: one instance with a 1-cycle ULA stub, one with a combinational stub.
module tb_ula_ctrl;
  import ula_ctrl_pkg::*;

  typedef struct {
    logic [8:0] s;
    logic       id;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [8:0] stub_a;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  ula_ctrl_if #(.WIDTH(8), .OPW(3)) ifa ();
  ula_ctrl_if #(.WIDTH(8), .OPW(3)) ifb ();

  ula_ctrl #(.WIDTH(8), .OPW(3), .ULA_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a));
  ula_ctrl #(.WIDTH(8), .OPW(3), .ULA_LAT(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b));

  // ULA stubs: add for OP_ADD, zero otherwise
  always @(posedge clk)
    stub_a <= (ifa.ula_op == OP_ADD) ? (9'(ifa.ula_a) + 9'(ifa.ula_b)) : 9'h000;
  assign ifa.ula_s = stub_a;
  assign ifb.ula_s = (ifb.ula_op == OP_ADD) ? (9'(ifb.ula_a) + 9'(ifb.ula_b)) : 9'h000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Response monitors: compare on the first cycle of each rsp_valid pulse
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_n) pv_a <= 1'b0;
    else begin
      pv_a <= ifa.rsp_valid;
      if (ifa.rsp_valid && !pv_a) begin
        if (qa.size() == 0) fail_now("a_unexpected_rsp", "rsp_valid with nothing outstanding");
        else begin
          e = qa.pop_front();
          check("a_rsp_s", 32'(ifa.rsp_s), 32'(e.s));
          check("a_rsp_id", 32'(ifa.rsp_id), 32'(e.id));
          check("a_rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_n) pv_b <= 1'b0;
    else begin
      pv_b <= ifb.rsp_valid;
      if (ifb.rsp_valid && !pv_b) begin
        if (qb.size() == 0) fail_now("b_unexpected_rsp", "rsp_valid with nothing outstanding");
        else begin
          e = qb.pop_front();
          check("b_rsp_s", 32'(ifb.rsp_s), 32'(e.s));
          check("b_rsp_id", 32'(ifb.rsp_id), 32'(e.id));
          check("b_rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Present one or two add requests to dut_a; first_id is the grant expected on a tie
  task automatic run_ops(input logic v0, input logic v1,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input logic [8:0] e0, input logic [8:0] e1,
                         input logic first_id);
    logic p0, p1, h0, h1, tie;
    exp_t e;
    p0 = v0; p1 = v1; tie = v0 && v1;
    ifa.req0_valid = v0; ifa.req0_a = a0; ifa.req0_b = b0; ifa.req0_op = OP_ADD;
    ifa.req1_valid = v1; ifa.req1_a = a1; ifa.req1_b = b1; ifa.req1_op = OP_ADD;
    for (int i = 0; i < 40 && (p0 || p1); i++) begin
      @(negedge clk);
      h0 = p0 && ifa.req0_ready;
      h1 = p1 && ifa.req1_ready;
      if (tie && (h0 || h1)) begin
        check("a_rr_first_grant", 32'({h1, h0}), first_id ? 32'h2 : 32'h1);
        tie = 1'b0;
      end
      if (h0) begin e.s = e0; e.id = 1'b0; e.cyc = cyc + 3; qa.push_back(e); end
      if (h1) begin e.s = e1; e.id = 1'b1; e.cyc = cyc + 3; qa.push_back(e); end
      @(posedge clk); #1;
      if (h0) begin ifa.req0_valid = 1'b0; p0 = 1'b0; end
      if (h1) begin ifa.req1_valid = 1'b0; p1 = 1'b0; end
    end
    if (p0 || p1) begin
      fail_now("a_accept_timeout", "request never accepted");
      ifa.req0_valid = 1'b0;
      ifa.req1_valid = 1'b0;
    end
  endtask

  // Single request to dut_b (combinational ULA)
  task automatic run_b(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [8:0] es);
    logic done;
    exp_t e;
    done = 1'b0;
    if (id) begin ifb.req1_valid = 1'b1; ifb.req1_a = a; ifb.req1_b = b; ifb.req1_op = OP_ADD; end
    else    begin ifb.req0_valid = 1'b1; ifb.req0_a = a; ifb.req0_b = b; ifb.req0_op = OP_ADD; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if ((id && ifb.req1_ready) || (!id && ifb.req0_ready)) begin
        e.s = es; e.id = id; e.cyc = cyc + 2; qb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    ifb.req0_valid = 1'b0;
    ifb.req1_valid = 1'b0;
    if (!done) fail_now("b_accept_timeout", "request never accepted");
  endtask

  task automatic drain(input logic sel);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (sel == 1'b0) done = (qa.size() == 0) && !ifa.rsp_valid && !busy_a;
      else             done = (qb.size() == 0) && !ifb.rsp_valid && !busy_b;
    end
    if (!done) fail_now(sel ? "b_drain_timeout" : "a_drain_timeout", "responses still outstanding");
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic saw;
    logic hs;
    ifa.req0_valid = 1'b0; ifa.req0_a = '0; ifa.req0_b = '0; ifa.req0_op = '0;
    ifa.req1_valid = 1'b0; ifa.req1_a = '0; ifa.req1_b = '0; ifa.req1_op = '0;
    ifa.rsp_ready  = 1'b1;
    ifb.req0_valid = 1'b0; ifb.req0_a = '0; ifb.req0_b = '0; ifb.req0_op = '0;
    ifb.req1_valid = 1'b0; ifb.req1_a = '0; ifb.req1_b = '0; ifb.req1_op = '0;
    ifb.rsp_ready  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_rsp_s", 32'(ifa.rsp_s), 32'h0);
    check("rst_rsp_id", 32'(ifa.rsp_id), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op, latency 1
    run_ops(1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 9'h002, 9'h000, 1'b0);
    drain(1'b0);
    check("ula_a_holds", 32'(ifa.ula_a), 32'h01);

    // Asynchronous reset mid-cycle with both valids driven
    @(posedge clk); #3;
    ifa.req0_valid = 1'b1;
    ifa.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_req0_ready", 32'(ifa.req0_ready), 32'h0);
    check("arst_req1_ready", 32'(ifa.req1_ready), 32'h0);
    check("arst_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("arst_busy", 32'(busy_a), 32'h0);
    check("arst_ula_a", 32'(ifa.ula_a), 32'h0);
    check("arst_ula_b", 32'(ifa.ula_b), 32'h0);
    check("arst_ula_op", 32'(ifa.ula_op), 32'h0);
    @(posedge clk); #1;
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention, then round-robin follow-ups
    run_ops(1'b1, 1'b1, 8'hFF, 8'h01, 8'h10, 8'h20, 9'h100, 9'h030, 1'b0);
    drain(1'b0);
    run_ops(1'b1, 1'b1, 8'h02, 8'h03, 8'h04, 8'h05, 9'h005, 9'h009, 1'b0);
    drain(1'b0);
    run_ops(1'b1, 1'b0, 8'h0A, 8'h0B, 8'h00, 8'h00, 9'h015, 9'h000, 1'b0);
    drain(1'b0);
    run_ops(1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 9'h033, 9'h077, 1'b1);
    drain(1'b0);

    // Backpressure: hold rsp_ready low for 5 cycles while req1 waits
    ifa.rsp_ready = 1'b0;
    run_ops(1'b1, 1'b0, 8'h80, 8'h80, 8'h00, 8'h00, 9'h100, 9'h000, 1'b0);
    ifa.req1_valid = 1'b1; ifa.req1_a = 8'h03; ifa.req1_b = 8'h04; ifa.req1_op = OP_ADD;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk);
      check("bp_wait_req1_ready", 32'(ifa.req1_ready), 32'h0);
      saw = ifa.rsp_valid;
    end
    if (!saw) fail_now("bp_rsp_timeout", "rsp_valid never rose");
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(ifa.rsp_valid), 32'h1);
      check("bp_rsp_s", 32'(ifa.rsp_s), 32'h100);
      check("bp_rsp_id", 32'(ifa.rsp_id), 32'h0);
      check("bp_req1_ready", 32'(ifa.req1_ready), 32'h0);
      @(posedge clk); #1;
      if (k < 4) @(negedge clk);
    end
    ifa.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(ifa.rsp_valid), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_busy", 32'(busy_a), 32'h0);
    check("bp_idle_rsp_valid", 32'(ifa.rsp_valid), 32'h0);
    check("bp_idle_req1_ready", 32'(ifa.req1_ready), 32'h1);
    if (ifa.req1_ready) begin : push_bp
      exp_t e;
      e.s = 9'h007; e.id = 1'b1; e.cyc = cyc + 3;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    ifa.req1_valid = 1'b0;
    drain(1'b0);

    // Reset while in WAIT drops the operation
    ifa.req0_valid = 1'b1; ifa.req0_a = 8'h05; ifa.req0_b = 8'h06; ifa.req0_op = OP_ADD;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = ifa.req0_ready;
      @(posedge clk); #1;
    end
    ifa.req0_valid = 1'b0;
    if (!hs) fail_now("wrst_accept_timeout", "request never accepted");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ifa.rsp_valid) saw = 1'b1;
    end
    check("wrst_no_rsp", 32'(saw), 32'h0);
    @(posedge clk); #1;
    run_ops(1'b0, 1'b1, 8'h00, 8'h00, 8'h09, 8'h0A, 9'h000, 9'h013, 1'b0);
    drain(1'b0);

    // Combinational ULA instance
    run_b(1'b1, 8'h7F, 8'h01, 9'h080);
    drain(1'b1);
    run_b(1'b0, 8'hFF, 8'hFF, 9'h1FE);
    drain(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
